// File: rtl/column_cast_sequencer_if.sv
// Signal bundle between the column sequencer, the ray caster, the column buffer
// and the frame requester. master = sequencer side, slave = environment side.
interface column_cast_sequencer_if;
  logic        frame_req;
  logic [6:0]  pose_angle;
  logic [15:0] pose_x;
  logic [15:0] pose_y;

  logic        cast_start;
  logic [8:0]  cast_x;
  logic [6:0]  cast_angle;
  logic [15:0] cast_pos_x;
  logic [15:0] cast_pos_y;
  logic        cast_busy;
  logic        cast_done;
  logic [7:0]  line_height;
  logic [3:0]  line_color;

  logic        fb_we;
  logic [8:0]  fb_addr;
  logic [19:0] fb_wdata;
  logic        fb_bank;
  logic        disp_bank;
  logic        frame_done;
  logic [12:0] frame_count;
  logic        timeout_err;

  modport master (
    input  frame_req, pose_angle, pose_x, pose_y,
    input  cast_busy, cast_done, line_height, line_color,
    output cast_start, cast_x, cast_angle, cast_pos_x, cast_pos_y,
    output fb_we, fb_addr, fb_wdata, fb_bank, disp_bank,
    output frame_done, frame_count, timeout_err
  );

  modport slave (
    output frame_req, pose_angle, pose_x, pose_y,
    output cast_busy, cast_done, line_height, line_color,
    input  cast_start, cast_x, cast_angle, cast_pos_x, cast_pos_y,
    input  fb_we, fb_addr, fb_wdata, fb_bank, disp_bank,
    input  frame_done, frame_count, timeout_err
  );
endinterface

// File: rtl/column_cast_sequencer.sv
// Frame sequencer: latches a pose, casts columns 0..WIDTH-1 one at a time, writes
// top/bottom bounds into the back bank and swaps banks only after a full frame.
module column_cast_sequencer #(
  parameter int unsigned WIDTH   = 320,
  parameter int unsigned HEIGHT  = 240,
  parameter int unsigned TIMEOUT = 1023
) (
  input logic                      CLK,
  input logic                      rst,
  column_cast_sequencer_if.master  bus
);

  localparam logic [8:0] LAST_COL = 9'(WIDTH - 1);
  localparam logic [7:0] HEIGHT_B = 8'(HEIGHT);
  localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_ISSUE, S_WAIT, S_WRITE, S_NEXT, S_SWAP
  } state_e;

  typedef struct packed {
    logic [6:0]  angle;
    logic [15:0] x;
    logic [15:0] y;
  } pose_t;

  state_e      state_q, state_d;
  logic [8:0]  col_q, col_d;
  logic        pending_q, pending_d;
  logic [9:0]  tmo_q, tmo_d;
  pose_t       pose_q, pose_d;
  logic        cast_start_q, cast_start_d;
  logic [8:0]  cast_x_q, cast_x_d;
  logic        fb_we_q, fb_we_d;
  logic [8:0]  fb_addr_q, fb_addr_d;
  logic [19:0] fb_wdata_q, fb_wdata_d;
  logic        disp_bank_q, disp_bank_d;
  logic        frame_done_q, frame_done_d;
  logic [12:0] frame_count_q, frame_count_d;
  logic        timeout_err_q, timeout_err_d;

  // Clamp to the screen and centre the wall slice vertically.
  function automatic logic [19:0] pack_column(input logic [7:0] h_raw, input logic [3:0] color);
    logic [7:0] h, top, bottom;
    h      = (h_raw > HEIGHT_B) ? HEIGHT_B : h_raw;
    top    = (HEIGHT_B - h) >> 1;
    bottom = top + h;
    return {bottom, top, color};
  endfunction

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves a latch behind.
    state_d       = state_q;
    col_d         = col_q;
    pending_d     = pending_q;
    tmo_d         = tmo_q;
    pose_d        = pose_q;
    cast_start_d  = 1'b0;
    cast_x_d      = cast_x_q;
    fb_we_d       = 1'b0;
    fb_addr_d     = fb_addr_q;
    fb_wdata_d    = fb_wdata_q;
    disp_bank_d   = disp_bank_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    timeout_err_d = timeout_err_q;

    if (state_q != S_IDLE && bus.frame_req) pending_d = 1'b1;

    // cast_start is registered, so the launch decision is made on the edge that
    // enters (or stays in) ISSUE; the ISSUE cycle carrying the pulse then moves on.
    unique case (state_q)
      S_IDLE: begin
        if (bus.frame_req || pending_q) begin
          pending_d = 1'b0;
          state_d   = S_LATCH;
        end
      end
      S_LATCH: begin
        pose_d       = '{angle: bus.pose_angle, x: bus.pose_x, y: bus.pose_y};
        col_d        = '0;
        cast_x_d     = '0;
        cast_start_d = ~bus.cast_busy;
        state_d      = S_ISSUE;
      end
      S_ISSUE: begin
        if (cast_start_q) begin
          tmo_d   = '0;
          state_d = S_WAIT;
        end else begin
          cast_x_d     = col_q;
          cast_start_d = ~bus.cast_busy;
        end
      end
      S_WAIT: begin
        if (bus.cast_done) begin
          fb_we_d    = 1'b1;
          fb_addr_d  = col_q;
          fb_wdata_d = pack_column(bus.line_height, bus.line_color);
          state_d    = S_WRITE;
        end else if (tmo_q == TMO_LAST) begin
          fb_we_d       = 1'b1;
          fb_addr_d     = col_q;
          fb_wdata_d    = pack_column(8'd0, 4'd0);
          timeout_err_d = 1'b1;
          state_d       = S_WRITE;
        end else begin
          tmo_d = tmo_q + 10'd1;
        end
      end
      S_WRITE: state_d = S_NEXT;
      S_NEXT: begin
        if (col_q == LAST_COL) begin
          disp_bank_d   = ~disp_bank_q;
          frame_done_d  = 1'b1;
          frame_count_d = frame_count_q + 13'd1;
          state_d       = S_SWAP;
        end else begin
          col_d        = col_q + 9'd1;
          cast_x_d     = col_q + 9'd1;
          cast_start_d = ~bus.cast_busy;
          state_d      = S_ISSUE;
        end
      end
      S_SWAP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: state updates use <= so every register samples pre-edge values.
    if (rst) begin
      state_q       <= S_IDLE;
      col_q         <= '0;
      pending_q     <= 1'b0;
      tmo_q         <= '0;
      pose_q        <= '0;
      cast_start_q  <= 1'b0;
      cast_x_q      <= '0;
      fb_we_q       <= 1'b0;
      fb_addr_q     <= '0;
      fb_wdata_q    <= '0;
      disp_bank_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      pending_q     <= pending_d;
      tmo_q         <= tmo_d;
      pose_q        <= pose_d;
      cast_start_q  <= cast_start_d;
      cast_x_q      <= cast_x_d;
      fb_we_q       <= fb_we_d;
      fb_addr_q     <= fb_addr_d;
      fb_wdata_q    <= fb_wdata_d;
      disp_bank_q   <= disp_bank_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.cast_start  = cast_start_q;
  assign bus.cast_x      = cast_x_q;
  assign bus.cast_angle  = pose_q.angle;
  assign bus.cast_pos_x  = pose_q.x;
  assign bus.cast_pos_y  = pose_q.y;
  assign bus.fb_we       = fb_we_q;
  assign bus.fb_addr     = fb_addr_q;
  assign bus.fb_wdata    = fb_wdata_q;
  assign bus.fb_bank     = ~disp_bank_q;
  assign bus.disp_bank   = disp_bank_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.frame_count = frame_count_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_column_cast_sequencer.sv
// Directed bench for column_cast_sequencer: a fixed-latency caster model answers
// each cast, a monitor logs writes/starts/swaps, and one initial block checks them.
module tb_column_cast_sequencer;
  localparam int W = 320;
  localparam int K = 5;

  logic CLK = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  column_cast_sequencer_if bus ();

  column_cast_sequencer #(.WIDTH(W), .HEIGHT(240), .TIMEOUT(1023)) dut (
    .CLK (CLK),
    .rst (rst),
    .bus (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // caster behaviour knobs, set by the stimulus block
  int mode     = 0;
  int skip_col = -1;
  int hold_col = -1;
  int hold_len = 20;

  // monitor log
  logic [19:0] wr_data [512];
  int          wr_cyc  [512];
  int          start_cyc [512];
  int wr_count, last_addr, order_bad, start_count, first_start, first_start_x;
  int done_count, done_cyc, bank_bad;

  function automatic logic [7:0] h_for(input int c);
    if (mode == 0) return 8'd100;
    return (c % 2 == 0) ? 8'd255 : 8'd0;
  endfunction

  function automatic logic [3:0] c_for(input int c);
    if (mode == 0) return 4'd1;
    return (c % 2 == 0) ? 4'd2 : 4'd3;
  endfunction

  // hand-computed column words {bottom, top, color} for HEIGHT=240
  function automatic logic [19:0] exp_word(input int a);
    if (a == skip_col) return {8'd120, 8'd120, 4'd0};
    if (mode == 0) return {8'd170, 8'd70, 4'd1};
    return (a % 2 == 0) ? {8'd240, 8'd0, 4'd2} : {8'd120, 8'd120, 4'd3};
  endfunction

  // caster model: done exactly K cycles after the start cycle
  initial begin : caster
    int c;
    bus.cast_busy   = 1'b0;
    bus.cast_done   = 1'b0;
    bus.line_height = '0;
    bus.line_color  = '0;
    forever begin
      @(negedge CLK);
      if (bus.cast_start === 1'b1) begin
        c = int'(bus.cast_x);
        if (c != skip_col) begin
          bus.cast_busy = 1'b1;
          repeat (K) @(negedge CLK);
          bus.line_height = h_for(c);
          bus.line_color  = c_for(c);
          bus.cast_done   = 1'b1;
          if (c != hold_col) bus.cast_busy = 1'b0;
          @(negedge CLK);
          bus.cast_done = 1'b0;
          if (c == hold_col) begin
            repeat (hold_len - 1) @(negedge CLK);
            bus.cast_busy = 1'b0;
          end
        end
      end
    end
  end

  initial begin : monitor
    int a;
    forever begin
      @(negedge CLK);
      if (bus.fb_we === 1'b1) begin
        a = int'(bus.fb_addr);
        if (a != ((wr_count % W == 0) ? 0 : last_addr + 1)) order_bad++;
        wr_data[a] = bus.fb_wdata;
        wr_cyc[a]  = cyc;
        last_addr  = a;
        wr_count++;
      end
      if (bus.cast_start === 1'b1) begin
        start_cyc[int'(bus.cast_x)] = cyc;
        if (start_count == 0) begin
          first_start   = cyc;
          first_start_x = int'(bus.cast_x);
        end
        start_count++;
      end
      if (bus.frame_done === 1'b1) begin
        done_count++;
        done_cyc = cyc;
      end
      if (bus.fb_bank !== ~bus.disp_bank) bank_bad++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic clear_stats();
    wr_count = 0; last_addr = 0; order_bad = 0; start_count = 0;
    first_start = -1; first_start_x = -1; done_count = 0; done_cyc = 0; bank_bad = 0;
  endtask

  task automatic pulse_req(output int t);
    bus.frame_req = 1'b1;
    t = cyc;
    step();
    bus.frame_req = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int n = 0;
    while (done_count < target && n < budget) begin
      step();
      n++;
    end
    check(tag, done_count, target);
  endtask

  task automatic wait_writes(input int target, input int budget, input string tag);
    int n = 0;
    while (wr_count < target && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(wr_count >= target), 32'd1);
  endtask

  task automatic check_frame_data(input string tag);
    int bad = 0;
    for (int i = 0; i < W; i++) if (wr_data[i] !== exp_word(i)) bad++;
    check(tag, bad, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " cast_start"}, bus.cast_start, 0);
    check({tag, " cast_x"}, bus.cast_x, 0);
    check({tag, " cast_angle"}, bus.cast_angle, 0);
    check({tag, " cast_pos_x"}, bus.cast_pos_x, 0);
    check({tag, " cast_pos_y"}, bus.cast_pos_y, 0);
    check({tag, " fb_we"}, bus.fb_we, 0);
    check({tag, " fb_addr"}, bus.fb_addr, 0);
    check({tag, " fb_wdata"}, bus.fb_wdata, 0);
    check({tag, " fb_bank"}, bus.fb_bank, 1);
    check({tag, " disp_bank"}, bus.disp_bank, 0);
    check({tag, " frame_done"}, bus.frame_done, 0);
    check({tag, " frame_count"}, bus.frame_count, 0);
    check({tag, " timeout_err"}, bus.timeout_err, 0);
  endtask

  initial begin : stim
    int t_req, sc;
    bus.frame_req  = 1'b0;
    bus.pose_angle = 7'd0;
    bus.pose_x     = 16'h0000;
    bus.pose_y     = 16'h0000;
    clear_stats();
    rst = 1'b1;
    repeat (3) step();
    check_reset_outputs("por");
    rst = 1'b0;

    // reset in the middle of a frame, around column 150
    bus.pose_x = 16'h0A0A; bus.pose_y = 16'h0B0B; bus.pose_angle = 7'd9;
    pulse_req(t_req);
    wait_writes(150, 2000, "reach col150");
    rst = 1'b1;
    step();
    check_reset_outputs("midrst");
    rst = 1'b0;
    clear_stats();
    repeat (30) step();
    check("midrst no write", wr_count, 0);
    check("midrst no start", start_count, 0);
    check("midrst no swap", done_count, 0);

    // frame 1: h=100 color=1 -> {170,70,1} everywhere
    bus.pose_x = 16'h1234; bus.pose_y = 16'h0567; bus.pose_angle = 7'd5;
    mode = 0;
    clear_stats();
    pulse_req(t_req);
    wait_done(1, 3000, "f1 frame_done");
    check("f1 first start latency", first_start - t_req, 2);
    check("f1 first cast_x", first_start_x, 0);
    check("f1 frame cycles", done_cyc - t_req + 1, W * (K + 3) + 3);
    check("f1 write count", wr_count, W);
    check("f1 write order", order_bad, 0);
    check("f1 word col0", wr_data[0], {8'd170, 8'd70, 4'd1});
    check("f1 word col319", wr_data[319], {8'd170, 8'd70, 4'd1});
    check_frame_data("f1 all words");
    check("f1 disp_bank", bus.disp_bank, 1);
    check("f1 fb_bank", bus.fb_bank, 0);
    check("f1 frame_count", bus.frame_count, 1);
    check("f1 cast_pos_x", bus.cast_pos_x, 16'h1234);
    check("f1 cast_pos_y", bus.cast_pos_y, 16'h0567);
    check("f1 cast_angle", bus.cast_angle, 5);
    check("f1 timeout_err", bus.timeout_err, 0);
    step();
    check("f1 frame_done pulse width", done_count, 1);
    check("f1 frame_done low", bus.frame_done, 0);

    // frame 2: clamp (h=255) / zero (h=0), busy held 20 extra cycles after column 10
    mode = 1; hold_col = 10;
    clear_stats();
    pulse_req(t_req);
    wait_done(1, 3000, "f2 frame_done");
    check("f2 write count", wr_count, W);
    check("f2 write order", order_bad, 0);
    check("f2 clamp word", wr_data[0], {8'd240, 8'd0, 4'd2});
    check("f2 zero word", wr_data[1], {8'd120, 8'd120, 4'd3});
    check_frame_data("f2 all words");
    // busy stays high until 20 cycles after done, so start waits K+21 instead of K+3
    check("f2 busy stall gap", start_cyc[11] - start_cyc[10], K + 21);
    check("f2 normal gap", start_cyc[12] - start_cyc[11], K + 3);
    check("f2 start count", start_count, W);
    check("f2 disp_bank", bus.disp_bank, 0);
    check("f2 frame_count", bus.frame_count, 2);
    check("f2 bank pairing", bank_bad, 0);

    // frame 3: column 7 never answered -> blank write after 1023 WAIT cycles
    mode = 0; hold_col = -1; skip_col = 7;
    clear_stats();
    pulse_req(t_req);
    wait_done(1, 4500, "f3 frame_done");
    check("f3 blank word", wr_data[7], {8'd120, 8'd120, 4'd0});
    check("f3 timeout delay", wr_cyc[7] - start_cyc[7], 1024);
    check("f3 next col word", wr_data[8], {8'd170, 8'd70, 4'd1});
    check("f3 write count", wr_count, W);
    check("f3 write order", order_bad, 0);
    check_frame_data("f3 all words");
    check("f3 timeout_err", bus.timeout_err, 1);
    check("f3 frame_count", bus.frame_count, 3);

    // frames 4+5: three mid-frame requests collapse into one extra frame
    skip_col = -1;
    bus.pose_x = 16'h2000;
    clear_stats();
    pulse_req(t_req);
    wait_writes(100, 2000, "f4 reach col100");
    bus.pose_x = 16'h3333;
    for (int i = 0; i < 3; i++) begin
      repeat (5) step();
      pulse_req(t_req);
    end
    check("f4 pose frozen mid", bus.cast_pos_x, 16'h2000);
    wait_done(1, 3000, "f4 frame_done");
    check("f4 pose frozen end", bus.cast_pos_x, 16'h2000);
    wait_done(2, 3000, "f5 frame_done");
    check("f5 pose relatched", bus.cast_pos_x, 16'h3333);
    check("f5 write order", order_bad, 0);
    sc = start_count;
    repeat (200) step();
    check("f5 idle no start", start_count, sc);
    check("f5 idle no swap", done_count, 2);
    check("f5 frame_count", bus.frame_count, 5);
    check("f5 timeout_err sticky", bus.timeout_err, 1);
    check("f5 bank pairing", bank_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
